// File: rtl/fifo_stream_drain_pkg.sv
// Shared types and helpers for the FIFO read-side stream drain.
package fifo_stream_drain_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2,
        DRAIN  = 2'd3
    } drain_state_t;

    function automatic int beat_width(input int burst_len);
        return (burst_len <= 1) ? 1 : $clog2(burst_len);
    endfunction

endpackage

// File: rtl/fifo_if.sv
// FIFO port bundle: the consumer side uses the master modport.
interface fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ren;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic                  almost_empty;

    modport master (
        output wen, wdata, ren,
        input  rdata, rvalid, empty, full, almost_full, almost_empty
    );

    modport slave (
        input  wen, wdata, ren,
        output rdata, rvalid, empty, full, almost_full, almost_empty
    );
endinterface

// File: rtl/fifo_drain_skid.sv
// Two-entry output buffer absorbing words that arrive while the stream stalls.
module fifo_drain_skid
    import fifo_stream_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_valid
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head_valid = (count != 2'd0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fifo_stream_drain.sv
// FIFO read-side consumer: credit-based reads, burst-framed valid/ready output.
// Optional statistics counters are enabled by defining FIFO_STREAM_DRAIN_STATS_EN.
module fifo_stream_drain
    import fifo_stream_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_if.master                fifo,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  idle,
    output logic                  err
`ifdef FIFO_STREAM_DRAIN_STATS_EN
    ,
    output logic [31:0]           words_out,
    output logic [31:0]           bursts_out
`endif
);

    localparam int              BW   = beat_width(BURST_LEN);
    localparam logic [BW-1:0]   LAST = BW'(BURST_LEN - 1);

    drain_state_t  state, state_nxt;
    logic          rd_allowed;
    logic          inflight;
    logic          post_rst;
    logic          pop;
    logic          push;
    logic          ren;
    logic [1:0]    count;
    logic [2:0]    credit;
    logic [BW-1:0] beat;
    logic [BW-1:0] iss;
    logic [BW-1:0] iss_nxt;

    assign pop    = m_tvalid & m_tready;
    assign credit = 3'(count) + 3'(inflight) - 3'(pop);
    assign ren    = rd_allowed & ~fifo.empty & (credit < 3'd2);
    assign push   = fifo.rvalid & inflight & ~post_rst;

    assign fifo.ren   = ren;
    assign fifo.wen   = 1'b0;
    assign fifo.wdata = '0;

    assign iss_nxt = ren ? ((iss == LAST) ? '0 : iss + 1'b1) : iss;

    fifo_drain_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo.rdata),
        .pop       (pop),
        .count     (count),
        .head_data (m_tdata),
        .head_valid(m_tvalid)
    );

    assign m_tlast = m_tvalid & (beat == LAST);
    assign idle    = (state == IDLE);

    // Boundary decisions use the post-issue counter so a read issued in the
    // same cycle as the stop request is still accounted to its burst.
    always_comb begin
        state_nxt  = state;
        rd_allowed = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = RUN;
            end
            RUN: begin
                rd_allowed = 1'b1;
                if (!enable) state_nxt = (iss_nxt == '0) ? DRAIN : FINISH;
            end
            FINISH: begin
                rd_allowed = 1'b1;
                if (enable)              state_nxt = RUN;
                else if (iss_nxt == '0)  state_nxt = DRAIN;
            end
            DRAIN: begin
                if (count == 2'd0 && !inflight) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            inflight <= 1'b0;
            post_rst <= 1'b1;
            err      <= 1'b0;
            beat     <= '0;
            iss      <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= ren;
            post_rst <= 1'b0;
            iss      <= iss_nxt;
            if (fifo.rvalid && !inflight && !post_rst) err <= 1'b1;
            if (pop) beat <= (beat == LAST) ? '0 : beat + 1'b1;
        end
    end

`ifdef FIFO_STREAM_DRAIN_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            words_out  <= '0;
            bursts_out <= '0;
        end else begin
            if (pop)            words_out  <= words_out + 32'd1;
            if (pop && m_tlast) bursts_out <= bursts_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Directed bench for fifo_stream_drain with a behavioural one-cycle-latency FIFO.
module tb_fifo_stream_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        idle;
    logic        err;
`ifdef FIFO_STREAM_DRAIN_STATS_EN
    logic [31:0] words_out;
    logic [31:0] bursts_out;
`endif

    fifo_if #(.DATA_WIDTH(32)) fif();

    fifo_stream_drain #(
        .DATA_WIDTH(32),
        .BURST_LEN (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .fifo    (fif),
        .enable  (enable),
        .m_tdata (m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tlast (m_tlast),
        .idle    (idle),
        .err     (err)
`ifdef FIFO_STREAM_DRAIN_STATS_EN
        ,
        .words_out (words_out),
        .bursts_out(bursts_out)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO model: words pushed by the stimulus, popped on ren with rdata/rvalid one cycle later
    logic [31:0] q[$];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic        force_empty = 1'b0;
    logic        inj = 1'b0;
    logic        rv_real = 1'b0;

    assign fif.empty        = force_empty || (wr_cnt == rd_cnt);
    assign fif.full         = 1'b0;
    assign fif.almost_full  = 1'b0;
    assign fif.almost_empty = 1'b0;

    task automatic load(input logic [31:0] w);
        q.push_back(w);
        wr_cnt++;
    endtask

    // Scoreboard / monitor state
    logic [31:0] exp_q[$];
    int          occ = 0;
    int          mbeat = 0;
    int          nren = 0;
    int          npop = 0;
    int          viol = 0;
    logic        prev_rst = 1'b1;

    always @(posedge clk) begin
        logic        p;
        logic [31:0] exd;
        if (rst) begin
            exp_q.delete();
            occ   = 0;
            mbeat = 0;
        end else begin
            p = m_tvalid && m_tready;
            if (fif.rvalid && rv_real && !prev_rst) exp_q.push_back(fif.rdata);
            if (fif.ren && fif.empty) viol++;
            if (fif.ren && (occ - int'(p)) >= 2) viol++;
            if (p) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exd = exp_q.pop_front();
                    check("sb_data", m_tdata, exd);
                    check("sb_last", 32'(m_tlast), 32'(mbeat == 3));
                end
                mbeat = (mbeat + 1) % 4;
                npop++;
            end
            if (fif.ren) nren++;
            occ = occ + int'(fif.ren) - int'(p);
        end
        prev_rst = rst;

        if (fif.ren && !fif.empty) begin
            fif.rdata  <= q.pop_front();
            fif.rvalid <= 1'b1;
            rv_real    <= 1'b1;
            rd_cnt     <= rd_cnt + 1;
        end else begin
            fif.rdata  <= inj ? 32'hBAD0_BAD0 : 32'h0;
            fif.rvalid <= inj;
            rv_real    <= 1'b0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        enable      = 1'b0;
        m_tready    = 1'b0;
        inj         = 1'b0;
        force_empty = 1'b0;
        q.delete();
        wr_cnt = rd_cnt;
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        nren = 0;
        npop = 0;
    endtask

    task automatic wait_pops(input string name, input int n, input int budget);
        for (int i = 0; i < budget && npop < n; i++) @(negedge clk);
        check(name, 32'(npop), 32'(n));
    endtask

    typedef struct {
        logic        en;
        logic        rdy;
        logic        exp_ren;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_last;
        logic        exp_idle;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs = '{
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 32'd1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 32'd2, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 32'd3, 1'b1, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 32'd4, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 32'd5, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 32'd6, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 32'd7, 1'b1, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b1, 32'd8, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b1, 32'd9, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0}
        };

        rst = 1'b1; enable = 1'b0; m_tready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_ren",    32'(fif.ren),  32'd0);
        check("rst_wen",    32'(fif.wen),  32'd0);
        check("rst_wdata",  fif.wdata,     32'd0);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tdata",  m_tdata,       32'd0);
        check("rst_tlast",  32'(m_tlast),  32'd0);
        check("rst_err",    32'(err),      32'd0);
        check("rst_idle",   32'(idle),     32'd1);

        // Back-to-back stream with burst framing
        do_reset();
        for (int i = 0; i < 10; i++) load(32'(i));
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            enable   = vecs[i].en;
            m_tready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d_ren", i),    32'(fif.ren),  32'(vecs[i].exp_ren));
            check($sformatf("vec%0d_tvalid", i), 32'(m_tvalid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_tdata", i),  m_tdata,       vecs[i].exp_data);
            check($sformatf("vec%0d_tlast", i),  32'(m_tlast),  32'(vecs[i].exp_last));
            check($sformatf("vec%0d_idle", i),   32'(idle),     32'(vecs[i].exp_idle));
        end
        check("b2b_err", 32'(err), 32'd0);

        // Ready toggling every cycle
        do_reset();
        for (int i = 0; i < 10; i++) load(32'h100 + 32'(i));
        @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < 100 && npop < 10; i++) begin
            @(negedge clk);
            m_tready = ~m_tready;
        end
        check("toggle_pops", 32'(npop), 32'd10);
        check("toggle_err",  32'(err),  32'd0);

        // Stop mid-burst: two reads issued, then finish the burst of four
        do_reset();
        for (int i = 0; i < 10; i++) load(32'h200 + 32'(i));
        m_tready = 1'b1;
        @(negedge clk); enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); enable = 1'b0;
        #1 check("stop_ren_before", 32'(nren), 32'd2);
        @(negedge clk);
        @(negedge clk);
        #1 check("stop_ren_after", 32'(nren), 32'd4);
        check("stop_drain_noren", 32'(fif.ren), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 check("stop_idle_c7", 32'(idle), 32'd0);
        @(negedge clk);
        #1 check("stop_idle_c8", 32'(idle), 32'd1);
        check("stop_pops", 32'(npop), 32'd4);
        repeat (5) @(negedge clk);
        check("stop_no_more_ren", 32'(nren), 32'd4);

        // Empty FIFO throughout
        do_reset();
        force_empty = 1'b1;
        @(negedge clk); enable = 1'b1; m_tready = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("empty_nren",   32'(nren),     32'd0);
        check("empty_ren",    32'(fif.ren),  32'd0);
        check("empty_tvalid", 32'(m_tvalid), 32'd0);
        check("empty_idle",   32'(idle),     32'd0);
        force_empty = 1'b0;

        // Spurious rvalid with nothing outstanding
        do_reset();
        load(32'hA5A5_0001);
        load(32'hA5A5_0002);
        @(negedge clk); enable = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("inj_pre_tvalid", 32'(m_tvalid), 32'd1);
        check("inj_pre_err",    32'(err),      32'd0);
        inj = 1'b1;
        @(negedge clk); inj = 1'b0;
        @(negedge clk);
        #1;
        check("inj_err",   32'(err), 32'd1);
        check("inj_tdata", m_tdata,  32'hA5A5_0001);
        m_tready = 1'b1;
        wait_pops("inj_pops", 2, 20);
        repeat (3) @(negedge clk);
        #1;
        check("inj_err_sticky", 32'(err),      32'd1);
        check("inj_no_extra",   32'(m_tvalid), 32'd0);
        check("inj_npop",       32'(npop),     32'd2);

        // Reset with a full buffer, then a trailing rvalid
        do_reset();
        for (int i = 0; i < 4; i++) load(32'h300 + 32'(i));
        @(negedge clk); enable = 1'b1;
        repeat (6) @(negedge clk);
        #1 check("mrst_pre_tvalid", 32'(m_tvalid), 32'd1);
        rst = 1'b1; enable = 1'b0; inj = 1'b1;
        @(negedge clk);
        rst = 1'b0; inj = 1'b0;
        #1;
        check("mrst_ren",    32'(fif.ren),  32'd0);
        check("mrst_tvalid", 32'(m_tvalid), 32'd0);
        check("mrst_tdata",  m_tdata,       32'd0);
        check("mrst_tlast",  32'(m_tlast),  32'd0);
        check("mrst_idle",   32'(idle),     32'd1);
        check("mrst_err",    32'(err),      32'd0);
        @(negedge clk);
        #1 check("mrst_trailing_err", 32'(err), 32'd0);

        check("credit_rule", 32'(viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
